// File: rtl/adder_sum_accum.sv
// ============================================================================
// Module   : adder_sum_accum
// Brief    : Accumulates FRAME_LEN 3-bit adder results into a WIDTH-bit frame
//            total with overflow flag over a valid/ready output handshake.
//            Optional macro ACC_SAT_EN: saturate the total instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_sum_accum #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             err
);

    localparam int               c_cnt_w     = $clog2(FRAME_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_frame_len = c_cnt_w'(FRAME_LEN);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
    localparam logic [WIDTH-1:0] c_acc_max   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_legal;
    logic [WIDTH:0]       w_sum;
    logic                 w_carry;
    logic [WIDTH-1:0]     w_acc_next;
    logic [c_cnt_w-1:0]   w_cnt_next;

    assign w_accept   = in_valid & in_ready;
    assign w_legal    = (in_data != 3'd7);
    // One extra bit so the carry out of the accumulator is visible.
    assign w_sum      = {1'b0, r_acc} + (WIDTH + 1)'(in_data);
    assign w_carry    = w_sum[WIDTH];
    assign w_cnt_next = r_cnt + c_one;

`ifdef ACC_SAT_EN
    // Once the frame has overflowed the total stays pinned at full scale.
    assign w_acc_next = (w_carry | r_ovf) ? c_acc_max : w_sum[WIDTH-1:0];
`else
    assign w_acc_next = w_sum[WIDTH-1:0];
`endif

    assign in_ready  = (r_state != S_DONE);
    assign out_valid = (r_state == S_DONE);
    assign out_sum   = out_valid ? r_acc : '0;
    assign out_ovf   = out_valid & r_ovf;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_acc   <= WIDTH'(in_data);
                            r_cnt   <= c_one;
                            r_ovf   <= 1'b0;
                            r_state <= (FRAME_LEN == 1) ? S_DONE : S_ACCUM;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_acc <= w_acc_next;
                            r_cnt <= w_cnt_next;
                            if (w_carry) begin
                                r_ovf <= 1'b1;
                            end
                            if (w_cnt_next == c_frame_len) begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_sum_accum.sv
// ============================================================================
// Module   : tb_adder_sum_accum
// Brief    : Self-checking bench for adder_sum_accum (WIDTH=8 and WIDTH=4
//            instances in lockstep) against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_sum_accum;

    localparam int FRAME_LEN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic [2:0] in_data;
    logic       out_ready;

    logic       in_ready8, out_valid8, out_ovf8, err8;
    logic [7:0] out_sum8;
    logic       in_ready4, out_valid4, out_ovf4, err4;
    logic [3:0] out_sum4;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level model: samples taken so far and their plain integer total.
    int m_count = 0;
    int m_total = 0;
    bit m_hold = 0;
    bit m_err = 0;
    bit m_last_acc = 0;
    bit m_started = 0;

    always #5 clk = ~clk;

    adder_sum_accum #(.WIDTH(8), .FRAME_LEN(FRAME_LEN)) u_dut8 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_sum(out_sum8), .out_ovf(out_ovf8), .err(err8)
    );

    adder_sum_accum #(.WIDTH(4), .FRAME_LEN(FRAME_LEN)) u_dut4 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_sum(out_sum4), .out_ovf(out_ovf4), .err(err4)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int exp_sum(int total, int w);
        int max_v;
        max_v = (1 << w) - 1;
`ifdef ACC_SAT_EN
        return (total > max_v) ? max_v : total;
`else
        return total % (1 << w);
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_started  <= 1'b1;
            m_count    <= 0;
            m_total    <= 0;
            m_hold     <= 1'b0;
            m_err      <= 1'b0;
            m_last_acc <= 1'b0;
        end else if (clear) begin
            m_count    <= 0;
            m_total    <= 0;
            m_hold     <= 1'b0;
            m_last_acc <= 1'b0;
        end else if (m_hold) begin
            m_last_acc <= 1'b0;
            if (out_ready) begin
                m_hold  <= 1'b0;
                m_count <= 0;
                m_total <= 0;
            end
        end else begin
            m_last_acc <= in_valid;
            if (in_valid) begin
                if (in_data == 3'd7) begin
                    m_err <= 1'b1;
                end else begin
                    m_total <= m_total + int'(in_data);
                    m_count <= m_count + 1;
                    if (m_count + 1 == FRAME_LEN) m_hold <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("in_ready8",  {31'd0, in_ready8},  {31'd0, !m_hold});
            check("out_valid8", {31'd0, out_valid8}, {31'd0, m_hold});
            check("out_sum8",   {24'd0, out_sum8},   m_hold ? exp_sum(m_total, 8) : 0);
            check("out_ovf8",   {31'd0, out_ovf8},   {31'd0, m_hold && (m_total > 255)});
            check("err8",       {31'd0, err8},       {31'd0, m_err});
            check("in_ready4",  {31'd0, in_ready4},  {31'd0, !m_hold});
            check("out_valid4", {31'd0, out_valid4}, {31'd0, m_hold});
            check("out_sum4",   {28'd0, out_sum4},   m_hold ? exp_sum(m_total, 4) : 0);
            check("out_ovf4",   {31'd0, out_ovf4},   {31'd0, m_hold && (m_total > 15)});
            check("err4",       {31'd0, err4},       {31'd0, m_err});
        end
    end

    task automatic send(input logic [2:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        do begin
            @(negedge clk);
            n++;
        end while (!m_last_acc && n < 20);
        n_checks++;
        if (!m_last_acc) begin
            n_errors++;
            $display("FAIL send_timeout: sample %0d not accepted within %0d cycles", v, n);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 3'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready",  {31'd0, in_ready8},  1);
        check("rst_out_valid", {31'd0, out_valid8}, 0);
        check("rst_out_sum",   {24'd0, out_sum8},   0);
        check("rst_out_ovf",   {31'd0, out_ovf8},   0);
        check("rst_err",       {31'd0, err8},       0);

        // Basic frame with the consumer always ready.
        send(3'd3); send(3'd6); send(3'd1); send(3'd4);
        check("f1_valid", {31'd0, out_valid8}, 1);
        check("f1_sum",   {24'd0, out_sum8},   14);
        check("f1_ovf",   {31'd0, out_ovf8},   0);
        @(negedge clk);
        check("f1_idle_valid", {31'd0, out_valid8}, 0);
        check("f1_idle_ready", {31'd0, in_ready8},  1);

        // Backpressure: total held stable until the consumer takes it.
        out_ready = 1'b0;
        send(3'd3); send(3'd6); send(3'd1); send(3'd4);
        repeat (3) begin
            check("bp_valid", {31'd0, out_valid8}, 1);
            check("bp_sum",   {24'd0, out_sum8},   14);
            check("bp_ready", {31'd0, in_ready8},  0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, out_valid8}, 0);

        // Overflow on the narrow instance.
        send(3'd6); send(3'd6); send(3'd6); send(3'd0);
`ifdef ACC_SAT_EN
        check("w4_sum", {28'd0, out_sum4}, 15);
`else
        check("w4_sum", {28'd0, out_sum4}, 2);
`endif
        check("w4_ovf",  {31'd0, out_ovf4}, 1);
        check("w8_sum",  {24'd0, out_sum8}, 18);
        check("w8_ovf",  {31'd0, out_ovf8}, 0);
        @(negedge clk);

        // Illegal sample consumed but not counted.
        send(3'd5); send(3'd7);
        check("ill_err", {31'd0, err8}, 1);
        send(3'd2); send(3'd1); send(3'd3);
        check("ill_sum",       {24'd0, out_sum8}, 11);
        check("ill_ovf",       {31'd0, out_ovf8}, 0);
        check("ill_err_stays", {31'd0, err8},     1);
        @(negedge clk);

        // Reset mid-frame discards the partial frame.
        send(3'd2); send(3'd2);
        in_valid = 1'b1; in_data = 3'd1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        repeat (2) begin
            check("rst_mid_no_valid", {31'd0, out_valid8}, 0);
            @(negedge clk);
        end
        send(3'd1); send(3'd1); send(3'd1); send(3'd1);
        check("rst_mid_sum", {24'd0, out_sum8}, 4);
        @(negedge clk);

        // Clear mid-frame discards the partial frame.
        send(3'd2); send(3'd2);
        in_valid = 1'b1; in_data = 3'd1; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        check("clr_no_valid", {31'd0, out_valid8}, 0);
        send(3'd1); send(3'd1); send(3'd1); send(3'd1);
        check("clr_sum", {24'd0, out_sum8}, 4);
        @(negedge clk);

        // Randomized traffic checked every cycle by the compare process.
        repeat (600) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            if (clear && in_data == 3'd7) in_data = 3'd0;
            reset     = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
